// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared select encodings, pipeline slot shadow type and forward-select rule.
package pipe_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  typedef struct packed {
    logic             v;
    logic             wreg;
    logic             m2reg;
    logic [REG_W-1:0] dest;
  } slot_t;
  localparam slot_t SLOT_NONE = '0;
  // A load still in EX cannot feed the next consumer; it can once it reaches MEM (as WB data).
  function automatic logic [1:0] fwd_sel(input logic u, input logic [REG_W-1:0] r,
                                         input slot_t ex, input slot_t mem,
                                         input logic [REG_W-1:0] rz);
    return (!u || r == rz) ? FWD_REG :
           (ex.v && ex.wreg && !ex.m2reg && r == ex.dest) ? FWD_MEM :
           (mem.v && mem.wreg && r == mem.dest) ? FWD_WB : FWD_REG;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: EX forwarding selects, load-use stall and taken-branch squash.
module hazard_fwd_ctrl import pipe_ctrl_pkg::*; #(
  parameter int               CNT_W = 16,
  parameter logic [REG_W-1:0] RZERO = 5'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [REG_W-1:0] id_dest,
  input  logic             ex_branch_taken,
  output logic [1:0]       ex_fwa,
  output logic [1:0]       ex_fwb,
  output logic             stall,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  slot_t      ex_s_q, ex_s_d, mem_s_q;
  logic [1:0] fwa_q, fwa_d, fwb_q, fwb_d;
  logic       luse;
  always_comb begin
    luse = id_valid && ex_s_q.v && ex_s_q.m2reg && ex_s_q.dest != RZERO &&
           ((id_use_rs && id_rs == ex_s_q.dest) || (id_use_rt && id_rt == ex_s_q.dest));
    flush_ifid  = ex_branch_taken;
    stall       = luse && !ex_branch_taken;
    bubble_idex = stall || ex_branch_taken || !id_valid;
    ex_s_d = bubble_idex ? SLOT_NONE
                         : slot_t'{v: 1'b1, wreg: id_wreg, m2reg: id_m2reg, dest: id_dest};
    fwa_d  = bubble_idex ? FWD_REG : fwd_sel(id_use_rs, id_rs, ex_s_q, mem_s_q, RZERO);
    fwb_d  = bubble_idex ? FWD_REG : fwd_sel(id_use_rt, id_rt, ex_s_q, mem_s_q, RZERO);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_s_q  <= SLOT_NONE;
      mem_s_q <= SLOT_NONE;
      fwa_q   <= FWD_REG;
      fwb_q   <= FWD_REG;
    end else begin
      ex_s_q  <= ex_s_d;
      mem_s_q <= ex_s_q;
      fwa_q   <= fwa_d;
      fwb_q   <= fwb_d;
    end
  end
  assign ex_fwa = fwa_q;
  assign ex_fwb = fwb_q;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(stall), .count(stall_count)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(ex_branch_taken), .count(flush_count)
  );
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed plan scenarios plus random traffic against an instruction-history model.
module tb_hazard_fwd_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, ex_branch_taken;
  logic [4:0] id_rs, id_rt, id_dest;
  logic [1:0] ex_fwa, ex_fwb, s_fwa, s_fwb;
  logic stall, flush_ifid, bubble_idex, s_stall, s_flush, s_bubble;
  logic [15:0] stall_count, flush_count;
  logic [1:0] s_stall_count, s_flush_count;

  hazard_fwd_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_dest(id_dest), .ex_branch_taken(ex_branch_taken), .ex_fwa(ex_fwa), .ex_fwb(ex_fwb),
    .stall(stall), .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
    .stall_count(stall_count), .flush_count(flush_count)
  );
  hazard_fwd_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_dest(id_dest), .ex_branch_taken(ex_branch_taken), .ex_fwa(s_fwa), .ex_fwb(s_fwb),
    .stall(s_stall), .flush_ifid(s_flush), .bubble_idex(s_bubble),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  // hist[0] = instruction now in EX, hist[1] = instruction now in MEM
  typedef struct {bit v; bit w; bit m; logic [4:0] d;} ins_t;
  ins_t hist [2];
  int vec = 0, bad = 0, sc = 0, fc = 0;
  logic [1:0] efa = 2'd0, efb = 2'd0;
  bit last_stall = 0;

  function automatic logic [1:0] want_sel(bit u, logic [4:0] r);
    if (!u || r == 5'd0) return 2'd0;
    if (hist[0].v && hist[0].w && !hist[0].m && hist[0].d == r) return 2'd1;
    if (hist[1].v && hist[1].w && hist[1].d == r) return 2'd2;
    return 2'd0;
  endfunction

  task automatic cycle();
    bit lu, es, eb;
    logic [1:0] nfa, nfb;
    logic [15:0] e16s, e16f;
    logic [1:0] e2s, e2f;
    lu = id_valid && hist[0].v && hist[0].m && hist[0].d != 5'd0 &&
         ((id_use_rs && id_rs == hist[0].d) || (id_use_rt && id_rt == hist[0].d));
    es = lu && !ex_branch_taken;
    eb = es || ex_branch_taken || !id_valid;
    #3;
    vec++; if (stall !== es) begin bad++; $display("FAIL stall got=%b want=%b t=%0t", stall, es, $time); end
    vec++; if (flush_ifid !== ex_branch_taken) begin bad++; $display("FAIL flush_ifid got=%b want=%b t=%0t", flush_ifid, ex_branch_taken, $time); end
    vec++; if (bubble_idex !== eb) begin bad++; $display("FAIL bubble_idex got=%b want=%b t=%0t", bubble_idex, eb, $time); end
    nfa = eb ? 2'd0 : want_sel(id_use_rs, id_rs);
    nfb = eb ? 2'd0 : want_sel(id_use_rt, id_rt);
    last_stall = es;
    @(posedge clk);
    if (!rst_n) begin
      hist[0] = '{0, 0, 0, 5'd0}; hist[1] = '{0, 0, 0, 5'd0};
      sc = 0; fc = 0; efa = 2'd0; efb = 2'd0; last_stall = 0;
    end else begin
      hist[1] = hist[0];
      hist[0] = eb ? '{0, 0, 0, 5'd0} : '{1, id_wreg, id_m2reg, id_dest};
      efa = nfa; efb = nfb;
      sc += int'(es); fc += int'(ex_branch_taken);
    end
    #1;
    e16s = sc > 65535 ? 16'hFFFF : 16'(sc);
    e16f = fc > 65535 ? 16'hFFFF : 16'(fc);
    e2s  = sc > 3 ? 2'd3 : 2'(sc);
    e2f  = fc > 3 ? 2'd3 : 2'(fc);
    vec++; if (ex_fwa !== efa) begin bad++; $display("FAIL ex_fwa got=%b want=%b t=%0t", ex_fwa, efa, $time); end
    vec++; if (ex_fwb !== efb) begin bad++; $display("FAIL ex_fwb got=%b want=%b t=%0t", ex_fwb, efb, $time); end
    vec++; if (stall_count !== e16s) begin bad++; $display("FAIL stall_count got=%0d want=%0d t=%0t", stall_count, e16s, $time); end
    vec++; if (flush_count !== e16f) begin bad++; $display("FAIL flush_count got=%0d want=%0d t=%0t", flush_count, e16f, $time); end
    vec++; if (s_stall_count !== e2s) begin bad++; $display("FAIL sat_stall_count got=%0d want=%0d t=%0t", s_stall_count, e2s, $time); end
    vec++; if (s_flush_count !== e2f) begin bad++; $display("FAIL sat_flush_count got=%0d want=%0d t=%0t", s_flush_count, e2f, $time); end
  endtask

  task automatic issue(bit v, logic [4:0] rs, logic [4:0] rt, bit urs, bit urt,
                       bit w, bit m, logic [4:0] d, bit br);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wreg = w; id_m2reg = m; id_dest = d; ex_branch_taken = br;
    cycle();
  endtask

  task automatic idle();
    issue(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle(); idle();
    rst_n = 1;
    vec++; if (ex_fwa !== 2'b00 || stall_count !== 16'd0) begin bad++; $display("FAIL reset_state fwa=%b cnt=%0d want 00/0", ex_fwa, stall_count); end
  endtask

  task automatic test_alu_dep();
    issue(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3, 0);
    issue(1, 5'd3, 5'd4, 1, 1, 1, 0, 5'd8, 0);
    vec++; if (ex_fwa !== 2'b01 || ex_fwb !== 2'b00) begin bad++; $display("FAIL alu_dep got=%b/%b want=01/00", ex_fwa, ex_fwb); end
    issue(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3, 0);
    issue(1, 5'd9, 5'd10, 1, 1, 1, 0, 5'd11, 0);
    issue(1, 5'd3, 5'd3, 1, 1, 1, 0, 5'd5, 0);
    vec++; if (ex_fwa !== 2'b10 || ex_fwb !== 2'b10) begin bad++; $display("FAIL dist2 got=%b/%b want=10/10", ex_fwa, ex_fwb); end
  endtask

  task automatic test_load_use();
    idle(); idle();
    issue(1, 5'd2, 5'd0, 1, 0, 1, 1, 5'd4, 0);
    issue(1, 5'd4, 5'd1, 1, 1, 1, 0, 5'd6, 0);
    issue(1, 5'd4, 5'd1, 1, 1, 1, 0, 5'd6, 0);
    vec++; if (ex_fwa !== 2'b10 || ex_fwb !== 2'b00) begin bad++; $display("FAIL load_use_sel got=%b/%b want=10/00", ex_fwa, ex_fwb); end
  endtask

  task automatic test_r0_precedence();
    issue(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd0, 0);
    issue(1, 5'd0, 5'd0, 1, 1, 1, 0, 5'd9, 0);
    vec++; if (ex_fwa !== 2'b00 || ex_fwb !== 2'b00) begin bad++; $display("FAIL r0 got=%b/%b want=00/00", ex_fwa, ex_fwb); end
    issue(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd7, 0);
    issue(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd7, 0);
    issue(1, 5'd7, 5'd7, 1, 1, 1, 0, 5'd8, 0);
    vec++; if (ex_fwa !== 2'b01 || ex_fwb !== 2'b01) begin bad++; $display("FAIL nearest got=%b/%b want=01/01", ex_fwa, ex_fwb); end
  endtask

  task automatic test_branch_vs_stall();
    issue(1, 5'd2, 5'd0, 1, 0, 1, 1, 5'd4, 0);
    issue(1, 5'd1, 5'd4, 1, 1, 1, 0, 5'd6, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      issue(1, 5'd2, 5'd0, 1, 0, 1, 1, 5'd12, 0);
      issue(1, 5'd12, 5'd0, 1, 0, 1, 1, 5'd13, 0);
      issue(1, 5'd12, 5'd0, 1, 0, 1, 1, 5'd13, 0);
    end
    vec++; if (s_stall_count !== 2'd3) begin bad++; $display("FAIL saturate got=%0d want=3", s_stall_count); end
  endtask

  task automatic test_mid_reset();
    issue(1, 5'd2, 5'd0, 1, 0, 1, 1, 5'd4, 0);
    rst_n = 0;
    issue(1, 5'd4, 5'd0, 1, 0, 1, 0, 5'd6, 0);
    rst_n = 1;
    issue(1, 5'd4, 5'd0, 1, 0, 1, 0, 5'd6, 0);
    vec++; if (stall_count !== 16'd0) begin bad++; $display("FAIL mid_reset cnt got=%0d want=0", stall_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        id_valid = $urandom_range(0, 7) != 0;
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
        id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
        id_wreg = 1'($urandom); id_m2reg = $urandom_range(0, 2) == 0;
        id_dest = 5'($urandom_range(0, 3));
      end
      ex_branch_taken = $urandom_range(0, 7) == 0;
      rst_n = $urandom_range(0, 99) != 0;
      cycle();
    end
    rst_n = 1;
  endtask

  initial begin
    hist[0] = '{0, 0, 0, 5'd0}; hist[1] = '{0, 0, 0, 5'd0};
    rst_n = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wreg = 0; id_m2reg = 0; id_dest = 0; ex_branch_taken = 0;
    @(posedge clk); #1;
    test_reset();
    test_alu_dep();
    test_load_use();
    test_r0_precedence();
    test_branch_vs_stall();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
